// File: rtl/spm_dp_ctrl_pkg.sv
// Shared types and constants for the dual-port scratch-pad memory controller.
package spm_dp_ctrl_pkg;

   typedef enum logic [0:0] {
      StClear = 1'b0,
      StReady = 1'b1
   } spm_state_e;

   localparam int unsigned SpmDataWDef = 32;
   localparam int unsigned SpmDepthDef = 4096;

   // Bus-level encodings of the read/write select and strobes.
   localparam logic SpmRead    = 1'b1;
   localparam logic SpmWrite   = 1'b0;
   localparam logic SpmEnableN = 1'b0;  // asserted level of an active-low strobe
   localparam logic MemEnable  = 1'b1;
   localparam logic MemDisable = 1'b0;

   // Word aligned and inside the array; any set bit above the index also fails here.
   function automatic logic spm_addr_ok(input logic [31:0] addr, input int unsigned depth);
      return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
   endfunction

endpackage

// File: rtl/spm_ram_dp.sv
// Bare dual-port byte-enabled array. Writes are synchronous, reads are combinational
// so a registering caller sees read-first data. Port B wins on overlapping bytes.
module spm_ram_dp #(
   parameter int unsigned DataW = 32,
   parameter int unsigned Depth = 4096,
   parameter int unsigned IdxW  = $clog2(Depth),
   parameter int unsigned BeW   = DataW / 8
) (
   input  logic             clk_i,
   input  logic             a_we_i,
   input  logic [IdxW-1:0]  a_idx_i,
   input  logic [BeW-1:0]   a_be_i,
   input  logic [DataW-1:0] a_wdata_i,
   output logic [DataW-1:0] a_rdata_o,
   input  logic             b_we_i,
   input  logic [IdxW-1:0]  b_idx_i,
   input  logic [BeW-1:0]   b_be_i,
   input  logic [DataW-1:0] b_wdata_i,
   output logic [DataW-1:0] b_rdata_o
);

   logic [DataW-1:0] mem_q [Depth];

   // Byte-lane writes; port B is assigned last so it overrides A on a shared byte.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < BeW; i++) begin
         if (a_we_i && a_be_i[i]) mem_q[a_idx_i][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
         if (b_we_i && b_be_i[i]) mem_q[b_idx_i][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
      end
   end

   assign a_rdata_o = mem_q[a_idx_i];
   assign b_rdata_o = mem_q[b_idx_i];

endmodule

// File: rtl/spm_dp_ctrl.sv
// Dual-port scratch-pad controller: address checking, post-reset zero-fill FSM,
// read-valid/error pipeline. Port A serves fetch, port B load/store.
// Define SPM_OUT_REG_EN to add one output register stage (read latency 2).
module spm_dp_ctrl
   import spm_dp_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = SpmDataWDef,
   parameter int unsigned DEPTH  = SpmDepthDef
) (
   input  logic                clk,
   input  logic                reset_,
   input  logic [31:0]         if_spm_addr,
   input  logic                if_spm_as_,
   input  logic                if_spm_rw,
   input  logic [DATA_W/8-1:0] if_spm_be,
   input  logic [DATA_W-1:0]   if_spm_wr_data,
   output logic [DATA_W-1:0]   if_spm_rd_data,
   output logic                if_spm_rd_vld,
   output logic                if_spm_err,
   input  logic [31:0]         mem_spm_addr,
   input  logic                mem_spm_as_,
   input  logic                mem_spm_rw,
   input  logic [DATA_W/8-1:0] mem_spm_be,
   input  logic [DATA_W-1:0]   mem_spm_wr_data,
   output logic [DATA_W-1:0]   mem_spm_rd_data,
   output logic                mem_spm_rd_vld,
   output logic                mem_spm_err,
   output logic                spm_busy
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned IDX_W = $clog2(DEPTH);

   spm_state_e       state_q, state_d;
   logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

   logic a_req, a_ok, a_rd, a_wr, a_err;
   logic b_req, b_ok, b_rd, b_wr, b_err;
   logic [DATA_W-1:0] a_rdata, b_rdata;

   logic              ram_b_we;
   logic [IDX_W-1:0]  ram_b_idx;
   logic [BE_W-1:0]   ram_b_be;
   logic [DATA_W-1:0] ram_b_wdata;

   logic [DATA_W-1:0] a_rd_data_q, a_rd_data_d, b_rd_data_q, b_rd_data_d;
   logic              a_rd_vld_q, a_err_q, b_rd_vld_q, b_err_q;

   assign spm_busy = (state_q == StClear);

   // Clear FSM state and fill index.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q   <= StClear;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   // Walk the array once after reset, then stay ready until the next reset.
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      unique case (state_q)
         StClear: begin
            if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
               state_d   = StReady;
               clr_idx_d = '0;
            end else begin
               clr_idx_d = clr_idx_q + 1'b1;
            end
         end
         StReady: ;
      endcase
   end

   // Request decode; nothing is accepted while the clear runs.
   always_comb begin
      a_req = !spm_busy && (if_spm_as_ == SpmEnableN);
      a_ok  = spm_addr_ok(if_spm_addr, DEPTH);
      a_rd  = a_req && a_ok && (if_spm_rw == SpmRead);
      a_wr  = a_req && a_ok && (if_spm_rw == SpmWrite);
      a_err = a_req && !a_ok;
      b_req = !spm_busy && (mem_spm_as_ == SpmEnableN);
      b_ok  = spm_addr_ok(mem_spm_addr, DEPTH);
      b_rd  = b_req && b_ok && (mem_spm_rw == SpmRead);
      b_wr  = b_req && b_ok && (mem_spm_rw == SpmWrite);
      b_err = b_req && !b_ok;
   end

   // The clear FSM borrows port B of the array.
   always_comb begin
      ram_b_we    = b_wr;
      ram_b_idx   = mem_spm_addr[IDX_W+1:2];
      ram_b_be    = mem_spm_be;
      ram_b_wdata = mem_spm_wr_data;
      if (spm_busy) begin
         ram_b_we    = MemEnable;
         ram_b_idx   = clr_idx_q;
         ram_b_be    = '1;
         ram_b_wdata = '0;
      end
   end

   spm_ram_dp #(
      .DataW (DATA_W),
      .Depth (DEPTH),
      .IdxW  (IDX_W),
      .BeW   (BE_W)
   ) u_ram (
      .clk_i     (clk),
      .a_we_i    (a_wr),
      .a_idx_i   (if_spm_addr[IDX_W+1:2]),
      .a_be_i    (if_spm_be),
      .a_wdata_i (if_spm_wr_data),
      .a_rdata_o (a_rdata),
      .b_we_i    (ram_b_we),
      .b_idx_i   (ram_b_idx),
      .b_be_i    (ram_b_be),
      .b_wdata_i (ram_b_wdata),
      .b_rdata_o (b_rdata)
   );

   // Read data holds between reads; a rejected read returns zero.
   always_comb begin
      a_rd_data_d = a_rd_data_q;
      b_rd_data_d = b_rd_data_q;
      if (a_rd) a_rd_data_d = a_rdata;
      else if (a_err && (if_spm_rw == SpmRead)) a_rd_data_d = '0;
      if (b_rd) b_rd_data_d = b_rdata;
      else if (b_err && (mem_spm_rw == SpmRead)) b_rd_data_d = '0;
   end

   // First response stage: capturing pre-edge array data makes reads read-first.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         a_rd_data_q <= '0;
         a_rd_vld_q  <= 1'b0;
         a_err_q     <= 1'b0;
         b_rd_data_q <= '0;
         b_rd_vld_q  <= 1'b0;
         b_err_q     <= 1'b0;
      end else begin
         a_rd_data_q <= a_rd_data_d;
         a_rd_vld_q  <= a_rd;
         a_err_q     <= a_err;
         b_rd_data_q <= b_rd_data_d;
         b_rd_vld_q  <= b_rd;
         b_err_q     <= b_err;
      end
   end

`ifdef SPM_OUT_REG_EN
   logic [DATA_W-1:0] a_out_data_q, b_out_data_q;
   logic              a_out_vld_q, a_out_err_q, b_out_vld_q, b_out_err_q;

   // Optional output stage: delays every response by one cycle.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         a_out_data_q <= '0;
         a_out_vld_q  <= 1'b0;
         a_out_err_q  <= 1'b0;
         b_out_data_q <= '0;
         b_out_vld_q  <= 1'b0;
         b_out_err_q  <= 1'b0;
      end else begin
         a_out_data_q <= a_rd_data_q;
         a_out_vld_q  <= a_rd_vld_q;
         a_out_err_q  <= a_err_q;
         b_out_data_q <= b_rd_data_q;
         b_out_vld_q  <= b_rd_vld_q;
         b_out_err_q  <= b_err_q;
      end
   end

   assign if_spm_rd_data  = a_out_data_q;
   assign if_spm_rd_vld   = a_out_vld_q;
   assign if_spm_err      = a_out_err_q;
   assign mem_spm_rd_data = b_out_data_q;
   assign mem_spm_rd_vld  = b_out_vld_q;
   assign mem_spm_err     = b_out_err_q;
`else
   assign if_spm_rd_data  = a_rd_data_q;
   assign if_spm_rd_vld   = a_rd_vld_q;
   assign if_spm_err      = a_err_q;
   assign mem_spm_rd_data = b_rd_data_q;
   assign mem_spm_rd_vld  = b_rd_vld_q;
   assign mem_spm_err     = b_err_q;
`endif

endmodule

// File: tb/tb_spm_dp_ctrl.sv
// Self-checking bench for spm_dp_ctrl (DEPTH=16) against a word-array reference model.
module tb_spm_dp_ctrl;
   import spm_dp_ctrl_pkg::*;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned DATA_W = 32;
`ifdef SPM_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct packed {
      logic        as_n;
      logic        rw;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
   } req_t;

   logic        clk, reset_;
   logic [31:0] if_spm_addr, mem_spm_addr;
   logic        if_spm_as_, if_spm_rw, mem_spm_as_, mem_spm_rw;
   logic [3:0]  if_spm_be, mem_spm_be;
   logic [31:0] if_spm_wr_data, mem_spm_wr_data, if_spm_rd_data, mem_spm_rd_data;
   logic        if_spm_rd_vld, if_spm_err, mem_spm_rd_vld, mem_spm_err, spm_busy;

   spm_dp_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .reset_          (reset_),
      .if_spm_addr     (if_spm_addr),
      .if_spm_as_      (if_spm_as_),
      .if_spm_rw       (if_spm_rw),
      .if_spm_be       (if_spm_be),
      .if_spm_wr_data  (if_spm_wr_data),
      .if_spm_rd_data  (if_spm_rd_data),
      .if_spm_rd_vld   (if_spm_rd_vld),
      .if_spm_err      (if_spm_err),
      .mem_spm_addr    (mem_spm_addr),
      .mem_spm_as_     (mem_spm_as_),
      .mem_spm_rw      (mem_spm_rw),
      .mem_spm_be      (mem_spm_be),
      .mem_spm_wr_data (mem_spm_wr_data),
      .mem_spm_rd_data (mem_spm_rd_data),
      .mem_spm_rd_vld  (mem_spm_rd_vld),
      .mem_spm_err     (mem_spm_err),
      .spm_busy        (spm_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: word array plus expected response of the last access.
   logic [31:0] mdl      [DEPTH];
   logic [31:0] exp_data [2];
   logic        exp_vld  [2];
   logic        exp_err  [2];
   // Observed outputs at the negedge after the k-th rising edge following a request.
   logic        vld_h  [2][LAT+2];
   logic        err_h  [2][LAT+2];
   logic [31:0] data_h [2][LAT+2];

   function automatic req_t f_idle();
      return '{as_n: 1'b1, rw: SpmRead, addr: 32'h0, be: 4'h0, wd: 32'h0};
   endfunction
   function automatic req_t f_rd(input logic [31:0] a);
      return '{as_n: 1'b0, rw: SpmRead, addr: a, be: 4'h0, wd: 32'h0};
   endfunction
   function automatic req_t f_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      return '{as_n: 1'b0, rw: SpmWrite, addr: a, be: be, wd: d};
   endfunction
   function automatic bit addr_ok(input logic [31:0] a);
      return ((a % 32'd4) == 32'd0) && ((a / 32'd4) < DEPTH);
   endfunction

   task automatic drive(input req_t ra, input req_t rb);
      if_spm_as_      = ra.as_n;
      if_spm_rw       = ra.rw;
      if_spm_addr     = ra.addr;
      if_spm_be       = ra.be;
      if_spm_wr_data  = ra.wd;
      mem_spm_as_     = rb.as_n;
      mem_spm_rw      = rb.rw;
      mem_spm_addr    = rb.addr;
      mem_spm_be      = rb.be;
      mem_spm_wr_data = rb.wd;
   endtask

   task automatic model_reset();
      for (int i = 0; i < int'(DEPTH); i++) mdl[i] = 32'h0;
      for (int p = 0; p < 2; p++) exp_data[p] = 32'h0;
   endtask

   // One-cycle request on both ports; predicts from the model, then records responses.
   task automatic apply(input req_t ra, input req_t rb);
      req_t r [2];
      r[0] = ra;
      r[1] = rb;
      for (int p = 0; p < 2; p++) begin
         exp_vld[p] = !r[p].as_n && addr_ok(r[p].addr) && (r[p].rw == SpmRead);
         exp_err[p] = !r[p].as_n && !addr_ok(r[p].addr);
         if (exp_vld[p]) exp_data[p] = mdl[int'(r[p].addr / 32'd4)];
         else if (exp_err[p] && r[p].rw == SpmRead) exp_data[p] = 32'h0;
      end
      // Writes land after both reads were predicted; B applied last wins shared bytes.
      for (int p = 0; p < 2; p++) begin
         if (!r[p].as_n && addr_ok(r[p].addr) && r[p].rw == SpmWrite)
            for (int i = 0; i < 4; i++)
               if (r[p].be[i]) mdl[int'(r[p].addr / 32'd4)][i*8 +: 8] = r[p].wd[i*8 +: 8];
      end
      @(negedge clk);
      drive(ra, rb);
      for (int k = 1; k <= LAT + 1; k++) begin
         @(posedge clk);
         if (k == 1) begin
            #1;
            drive(f_idle(), f_idle());
         end
         @(negedge clk);
         vld_h[0][k] = if_spm_rd_vld;  err_h[0][k] = if_spm_err;  data_h[0][k] = if_spm_rd_data;
         vld_h[1][k] = mem_spm_rd_vld; err_h[1][k] = mem_spm_err; data_h[1][k] = mem_spm_rd_data;
      end
   endtask

   // Counts busy cycles after reset release and tries accesses partway through.
   task automatic count_busy(output int cnt, output bit quiet);
      cnt   = 0;
      quiet = 1'b1;
      while (spm_busy === 1'b1 && cnt < 100) begin
         cnt++;
         if (cnt == 10) drive(f_rd(32'h0), f_wr(32'h0, 4'hF, 32'hDEADBEEF));
         else drive(f_idle(), f_idle());
         if ({if_spm_rd_vld, if_spm_err, mem_spm_rd_vld, mem_spm_err} !== 4'b0) quiet = 1'b0;
         @(negedge clk);
      end
      drive(f_idle(), f_idle());
   endtask

   task automatic test_reset();
      int cnt;
      bit quiet;
      reset_ = 1'b0;
      drive(f_idle(), f_idle());
      repeat (3) @(negedge clk);
      n_vec++;
      if (spm_busy !== 1'b1) begin
         n_err++; $display("FAIL reset_busy: got %b want 1", spm_busy);
      end
      n_vec++;
      if ({if_spm_rd_vld, if_spm_err, mem_spm_rd_vld, mem_spm_err} !== 4'b0 ||
          if_spm_rd_data !== 32'h0 || mem_spm_rd_data !== 32'h0) begin
         n_err++; $display("FAIL reset_outputs: got vld/err %b%b%b%b data %h %h want all 0",
                           if_spm_rd_vld, if_spm_err, mem_spm_rd_vld, mem_spm_err,
                           if_spm_rd_data, mem_spm_rd_data);
      end
      reset_ = 1'b1;
      count_busy(cnt, quiet);
      model_reset();
      n_vec++;
      if (cnt != int'(DEPTH)) begin
         n_err++; $display("FAIL busy_cycles: got %0d want %0d", cnt, DEPTH);
      end
      n_vec++;
      if (!quiet) begin
         n_err++; $display("FAIL busy_ignores: got response during clear want none");
      end
   endtask

   task automatic test_clear_read();
      apply(f_rd(32'h0), f_rd(32'h3C));
      n_vec++;
      if (vld_h[1][LAT] !== 1'b1 || data_h[1][LAT] !== 32'h0) begin
         n_err++; $display("FAIL t1_read3c: got vld %b data %h want 1 00000000",
                           vld_h[1][LAT], data_h[1][LAT]);
      end
      n_vec++;
      if (data_h[0][LAT] !== 32'h0) begin
         n_err++; $display("FAIL t1_word0_clear: got %h want 00000000", data_h[0][LAT]);
      end
      n_vec++;
      if (vld_h[1][LAT+1] !== 1'b0 || (LAT == 2 && vld_h[1][1] !== 1'b0)) begin
         n_err++; $display("FAIL t1_vld_pulse: got early %b late %b want 0 0",
                           vld_h[1][1], vld_h[1][LAT+1]);
      end
   endtask

   task automatic test_byte_enable();
      apply(f_idle(), f_wr(32'h10, 4'hF, 32'hAABBCCDD));
      apply(f_idle(), f_wr(32'h10, 4'h5, 32'h11223344));
      apply(f_rd(32'h10), f_idle());
      n_vec++;
      if (vld_h[0][LAT] !== 1'b1 || data_h[0][LAT] !== 32'hAA22CC44) begin
         n_err++; $display("FAIL t2_byte_merge: got vld %b data %h want 1 aa22cc44",
                           vld_h[0][LAT], data_h[0][LAT]);
      end
      n_vec++;
      if (vld_h[1][LAT] !== 1'b0) begin
         n_err++; $display("FAIL t2_write_no_vld: got %b want 0", vld_h[1][LAT]);
      end
   endtask

   task automatic test_collision();
      apply(f_wr(32'h20, 4'h3, 32'h01010101), f_wr(32'h20, 4'h6, 32'h02020202));
      apply(f_rd(32'h20), f_rd(32'h20));
      n_vec++;
      if (data_h[0][LAT] !== 32'h00020201) begin
         n_err++; $display("FAIL t3_collision: got %h want 00020201", data_h[0][LAT]);
      end
      n_vec++;
      if (data_h[1][LAT] !== 32'h00020201 || vld_h[1][LAT] !== 1'b1) begin
         n_err++; $display("FAIL t3_dual_read: got vld %b data %h want 1 00020201",
                           vld_h[1][LAT], data_h[1][LAT]);
      end
   endtask

   task automatic test_read_first();
      apply(f_idle(), f_wr(32'h08, 4'hF, 32'h5));
      apply(f_rd(32'h08), f_wr(32'h08, 4'hF, 32'h9));
      n_vec++;
      if (data_h[0][LAT] !== 32'h5) begin
         n_err++; $display("FAIL t4_read_first: got %h want 00000005", data_h[0][LAT]);
      end
      apply(f_rd(32'h08), f_idle());
      n_vec++;
      if (data_h[0][LAT] !== 32'h9) begin
         n_err++; $display("FAIL t4_new_data: got %h want 00000009", data_h[0][LAT]);
      end
   endtask

   task automatic test_errors();
      apply(f_rd(32'h42), f_idle());
      n_vec++;
      if (err_h[0][LAT] !== 1'b1 || vld_h[0][LAT] !== 1'b0 || data_h[0][LAT] !== 32'h0) begin
         n_err++; $display("FAIL t5_misaligned: got err %b vld %b data %h want 1 0 00000000",
                           err_h[0][LAT], vld_h[0][LAT], data_h[0][LAT]);
      end
      n_vec++;
      if (err_h[0][LAT+1] !== 1'b0) begin
         n_err++; $display("FAIL t5_err_pulse: got %b want 0", err_h[0][LAT+1]);
      end
      apply(f_idle(), f_wr(32'h40, 4'hF, 32'hFFFFFFFF));
      n_vec++;
      if (err_h[1][LAT] !== 1'b1) begin
         n_err++; $display("FAIL t5_range_write: got err %b want 1", err_h[1][LAT]);
      end
      apply(f_rd(32'h0), f_rd(32'h8000_0000));
      n_vec++;
      if (data_h[0][LAT] !== 32'h0) begin
         n_err++; $display("FAIL t5_no_wrap: got %h want 00000000", data_h[0][LAT]);
      end
      n_vec++;
      if (err_h[1][LAT] !== 1'b1 || vld_h[1][LAT] !== 1'b0) begin
         n_err++; $display("FAIL t5_upper_bits: got err %b vld %b want 1 0",
                           err_h[1][LAT], vld_h[1][LAT]);
      end
   endtask

   task automatic test_mid_reset();
      int cnt;
      bit quiet;
      @(negedge clk);
      reset_ = 1'b0;
      @(negedge clk);
      reset_ = 1'b1;
      repeat (7) @(posedge clk);
      #2 reset_ = 1'b0;
      #1;
      n_vec++;
      if (spm_busy !== 1'b1 || if_spm_rd_data !== 32'h0) begin
         n_err++; $display("FAIL mid_reset_state: got busy %b data %h want 1 00000000",
                           spm_busy, if_spm_rd_data);
      end
      @(negedge clk);
      reset_ = 1'b1;
      count_busy(cnt, quiet);
      model_reset();
      n_vec++;
      if (cnt != int'(DEPTH)) begin
         n_err++; $display("FAIL mid_reset_restart: got %0d want %0d", cnt, DEPTH);
      end
   endtask

   function automatic req_t rand_req();
      req_t r;
      r.as_n = ($urandom_range(0, 3) == 0);
      r.rw   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) != 0) r.addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else r.addr = $urandom();
      r.be = 4'($urandom());
      r.wd = $urandom();
      return r;
   endfunction

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         apply(rand_req(), rand_req());
         for (int p = 0; p < 2; p++) begin
            for (int k = 1; k <= LAT + 1; k++) begin
               n_vec++;
               if (vld_h[p][k] !== (exp_vld[p] && k == LAT) ||
                   err_h[p][k] !== (exp_err[p] && k == LAT)) begin
                  n_err++; $display("FAIL rand_flags: iter %0d port %0d k %0d got vld %b err %b want %b %b",
                                    n, p, k, vld_h[p][k], err_h[p][k],
                                    exp_vld[p] && k == LAT, exp_err[p] && k == LAT);
               end
               if (k >= LAT) begin
                  n_vec++;
                  if (data_h[p][k] !== exp_data[p]) begin
                     n_err++; $display("FAIL rand_data: iter %0d port %0d k %0d got %h want %h",
                                       n, p, k, data_h[p][k], exp_data[p]);
                  end
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_clear_read();
      test_byte_enable();
      test_collision();
      test_read_first();
      test_errors();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
